sic_dispatcher: RTL and testbench

Issue-side dispatcher feeding the array of single-instruction controllers (SICs). Accepts renamed `sic_packet_t` instructions in program order from the rename stage, buffers them in a small FIFO, stamps a monotonically increasing issue ID, and hands each one to exactly one idle SIC via the SIC `req_instr` / `packet_in` handshake. It sits between rename and the SIC array and supports a flush on PC redirect.

---
 rtl/sic_dispatcher.sv | 106 ++++++++++
 tb/tb_sic_dispatcher.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sic_dispatcher.sv
// sic_dispatcher: in-order FIFO that stamps issue IDs and hands each instruction to one idle SIC, round-robin.
// Define SIC_DISPATCH_BYPASS_EN to let an empty FIFO pass in_pkt straight to a SIC in the same cycle.
package sic_pkg;
    localparam int SIC_ID_W = 4;
    typedef struct packed {
        logic                valid;
        logic [SIC_ID_W-1:0] issue_id;
        logic [7:0]          opcode;
        logic [5:0]          rd;
        logic [15:0]         imm;
    } sic_packet_t;
endpackage

module sic_dispatcher
    import sic_pkg::*;
#(
    parameter int NUM_SICS = 4,
    parameter int ID_WIDTH = SIC_ID_W,
    parameter int DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  sic_packet_t            in_pkt,
    output logic                   in_ready,
    input  logic [NUM_SICS-1:0]    req_instr,
    output sic_packet_t            packet_out [NUM_SICS],
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int SW = $clog2(NUM_SICS);

    sic_packet_t         r_mem [DEPTH];
    logic [AW:0]         r_head, r_tail;
    logic [ID_WIDTH-1:0] r_id;
    logic [SW-1:0]       r_rr;
    logic [NUM_SICS-1:0] r_mask;

    logic                w_empty, w_full, w_found, w_byp, w_disp, w_push, w_pop;
    logic [NUM_SICS-1:0] w_elig;
    logic [SW-1:0]       w_sel, w_k;
    sic_packet_t         w_head;

    assign w_empty   = r_head == r_tail;
    assign w_full    = (r_head[AW] != r_tail[AW]) && (r_head[AW-1:0] == r_tail[AW-1:0]);
    assign in_ready  = !w_full && !flush;
    assign occupancy = r_tail - r_head;
    // A SIC strobed last cycle still shows req_instr high for one cycle.
    assign w_elig    = req_instr & ~r_mask;

    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_k     = '0;
        for (int i = 0; i < NUM_SICS; i++) begin
            w_k = SW'((int'(r_rr) + i) % NUM_SICS);
            if (!w_found && w_elig[w_k]) begin
                w_found = 1'b1;
                w_sel   = w_k;
            end
        end
    end

`ifdef SIC_DISPATCH_BYPASS_EN
    assign w_byp = w_empty && in_valid && !flush && w_found;
`else
    assign w_byp = 1'b0;
`endif

    assign w_disp = !flush && w_found && (!w_empty || w_byp);
    assign w_push = in_valid && in_ready && !w_byp;
    assign w_pop  = w_disp && !w_byp;
    assign w_head = w_byp ? in_pkt : r_mem[r_head[AW-1:0]];

    always_comb begin
        for (int k = 0; k < NUM_SICS; k++) packet_out[k] = '0;
        if (w_disp) begin
            packet_out[w_sel]          = w_head;
            packet_out[w_sel].valid    = 1'b1;
            packet_out[w_sel].issue_id = r_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_id   <= '0;
            r_rr   <= '0;
            r_mask <= '0;
        end else begin
            r_head <= flush ? '0 : r_head + PW'(w_pop);
            r_tail <= flush ? '0 : r_tail + PW'(w_push);
            r_mask <= w_disp ? NUM_SICS'(1) << w_sel : '0;
            if (w_disp) begin
                r_id <= r_id + ID_WIDTH'(1);
                r_rr <= (int'(w_sel) == NUM_SICS - 1) ? '0 : w_sel + SW'(1);
            end
        end
    end

    always_ff @(posedge clk)
        if (w_push) r_mem[r_tail[AW-1:0]] <= in_pkt;
endmodule

// File: tb/tb_sic_dispatcher.sv
// tb_sic_dispatcher: scoreboard bench; a queue model predicts every dispatch, directed checks follow the test plan.
module tb_sic_dispatcher;
    import sic_pkg::*;
    localparam int N = 4;
    localparam int D = 4;

    logic        clk = 0, rst_n = 0, in_valid = 0, flush = 0;
    sic_packet_t in_pkt = '0;
    logic        in_ready;
    logic [N-1:0] req_instr = '0;
    sic_packet_t packet_out [N];
    logic [2:0]  occupancy;

    int n_vec = 0, n_err = 0;
    bit run = 0;
    sic_packet_t mq[$];
    int m_id = 0, m_rr = 0;
    logic [N-1:0] m_mask = '0;
    int log_sic[$], log_id[$];

    always #5 clk = ~clk;

    sic_dispatcher #(.NUM_SICS(N), .ID_WIDTH(4), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pkt(in_pkt), .in_ready(in_ready),
        .req_instr(req_instr), .packet_out(packet_out), .flush(flush), .occupancy(occupancy)
    );

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model of the dispatcher evaluated mid-cycle, then advanced to next-edge state.
    always @(negedge clk) if (rst_n && run) begin
        logic [N-1:0] elig, vld, exp_vld;
        logic [$bits(sic_packet_t)-1:0] junk;
        int sel;
        bit found, disp, byp, rdy;
        sic_packet_t p;
        rdy = (mq.size() < D) && !flush;
        check("in_ready", in_ready, rdy);
        check("occupancy", occupancy, mq.size());
        elig = req_instr & ~m_mask;
        found = 0;
        sel = 0;
        for (int i = 0; i < N; i++)
            if (!found && elig[(m_rr + i) % N]) begin
                found = 1;
                sel = (m_rr + i) % N;
            end
`ifdef SIC_DISPATCH_BYPASS_EN
        byp = (mq.size() == 0) && in_valid && !flush && found;
`else
        byp = 0;
`endif
        disp = !flush && found && (mq.size() > 0 || byp);
        exp_vld = disp ? N'(1) << sel : '0;
        junk = '0;
        for (int k = 0; k < N; k++) begin
            vld[k] = packet_out[k].valid;
            if (!exp_vld[k]) junk |= packet_out[k];
        end
        check("valid_vec", vld, exp_vld);
        check("idle_zero", junk, 0);
        for (int k = 0; k < N; k++)
            if (vld[k]) begin
                log_sic.push_back(k);
                log_id.push_back(int'(packet_out[k].issue_id));
            end
        if (disp) begin
            p = byp ? in_pkt : mq.pop_front();
            check("payload", {packet_out[sel].opcode, packet_out[sel].rd, packet_out[sel].imm},
                  {p.opcode, p.rd, p.imm});
            check("issue_id", packet_out[sel].issue_id, m_id);
            m_id = (m_id + 1) % 16;
            m_rr = (sel + 1) % N;
            m_mask = N'(1) << sel;
        end else m_mask = '0;
        if (flush) mq.delete();
        else if (in_valid && rdy && !byp) mq.push_back(in_pkt);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        m_id = 0;
        m_rr = 0;
        m_mask = '0;
        log_sic.delete();
        log_id.delete();
    endtask

    task automatic do_reset();
        rst_n = 0;
        run = 0;
        in_valid = 0;
        flush = 0;
        req_instr = '0;
        model_reset();
        tick();
        tick();
        rst_n = 1;
        run = 1;
    endtask

    task automatic set_pkt(logic [7:0] op);
        in_pkt = '0;
        in_pkt.opcode = op;
        in_pkt.rd = op[5:0] ^ 6'h2a;
        in_pkt.imm = {op, ~op};
        in_pkt.valid = 1'b1;
        in_pkt.issue_id = 4'hf;
    endtask

    task automatic send(logic [7:0] op);
        bit acc;
        int t = 0;
        in_valid = 1;
        set_pkt(op);
        do begin
            @(negedge clk);
            acc = in_ready;
            tick();
            t++;
        end while (!acc && t < 50);
        if (!acc) check("send_timeout", 0, 1);
        in_valid = 0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (occupancy != 0 && t < 200) begin
            tick();
            t++;
        end
        check("drain", occupancy, 0);
        tick();
    endtask

    function automatic int at(int q[$], int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // single instruction, single idle SIC
        do_reset();
        check("rst_ready", in_ready, 1);
        check("rst_occ", occupancy, 0);
        req_instr = 4'b0001;
        send(8'h10);
        tick();
        check("t1_count", log_sic.size(), 1);
        check("t1_sic", at(log_sic, 0), 0);
        check("t1_id", at(log_id, 0), 0);

        // back-to-back to all idle SICs
        do_reset();
        req_instr = 4'b1111;
        for (int i = 0; i < 4; i++) send(8'h20 + 8'(i));
        wait_drain();
        check("t2_count", log_sic.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("t2_sic", at(log_sic, i), i);
            check("t2_id", at(log_id, i), i);
        end

        // fill to full, then a single SIC frees one slot
        do_reset();
        for (int i = 0; i < 4; i++) send(8'h30 + 8'(i));
        in_valid = 1;
        set_pkt(8'h34);
        tick();
        tick();
        check("t3_full_ready", in_ready, 0);
        check("t3_full_occ", occupancy, 4);
        req_instr = 4'b0100;
        tick();
        check("t3_ready_after", in_ready, 1);
        check("t3_sic", at(log_sic, 0), 2);
        tick();
        in_valid = 0;
        req_instr = 4'b1111;
        wait_drain();
        check("t3_count", log_sic.size(), 5);

        // flush with in_valid high; issue IDs continue from 5
        req_instr = '0;
        for (int i = 0; i < 3; i++) send(8'h40 + 8'(i));
        in_valid = 1;
        set_pkt(8'h4f);
        flush = 1;
        req_instr = 4'b1111;
        tick();
        flush = 0;
        in_valid = 0;
        check("t4_occ", occupancy, 0);
        log_sic.delete();
        log_id.delete();
        send(8'h50);
        wait_drain();
        check("t4_count", log_id.size(), 1);
        check("t4_id", at(log_id, 0), 5);

        // issue ID wraps after 16
        do_reset();
        req_instr = 4'b1111;
        for (int i = 0; i < 17; i++) send(8'h60 + 8'(i));
        wait_drain();
        check("t5_count", log_id.size(), 17);
        for (int i = 0; i < 17; i++) check("t5_id", at(log_id, i), i % 16);

        // asynchronous reset in the middle of a dispatch
        do_reset();
        send(8'h70);
        send(8'h71);
        req_instr = 4'b0001;
        #2;
        check("t6_pre_valid", packet_out[0].valid, 1);
        rst_n = 0;
        run = 0;
        #1;
        check("t6_ready", in_ready, 1);
        check("t6_occ", occupancy, 0);
        for (int k = 0; k < N; k++) check("t6_pkt_zero", packet_out[k], 0);
        model_reset();
        tick();
        tick();
        rst_n = 1;
        run = 1;
        check("t6_occ_after", occupancy, 0);
        send(8'h72);
        wait_drain();
        check("t6_id", at(log_id, 0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
